// File: rtl/qkv_read_scheduler_if.sv
// Q/K/V RAM read ports and the two output streams of qkv_read_scheduler.
// Signal directions are named from the scheduler's side (master).
interface qkv_read_scheduler_if #(
    parameter int DW = 128
);
    logic [9:0]    o_QueryRam_rdaddr;
    logic [9:0]    o_KeyRam_rdaddr;
    logic [9:0]    o_ValueRam_rdaddr;
    logic [DW-1:0] i_QueryRam_out;
    logic [DW-1:0] i_KeyRam_out;
    logic [DW-1:0] i_ValueRam_out;
    logic [DW-1:0] o_q_data;
    logic [DW-1:0] o_k_data;
    logic          o_qk_valid;
    logic          i_qk_ready;
    logic [DW-1:0] o_v_data;
    logic          o_v_valid;
    logic          i_v_ready;

    modport master (
        output o_QueryRam_rdaddr, o_KeyRam_rdaddr, o_ValueRam_rdaddr,
        input  i_QueryRam_out, i_KeyRam_out, i_ValueRam_out,
        output o_q_data, o_k_data, o_qk_valid,
        input  i_qk_ready,
        output o_v_data, o_v_valid,
        input  i_v_ready
    );

    modport slave (
        input  o_QueryRam_rdaddr, o_KeyRam_rdaddr, o_ValueRam_rdaddr,
        output i_QueryRam_out, i_KeyRam_out, i_ValueRam_out,
        input  o_q_data, o_k_data, o_qk_valid,
        output i_qk_ready,
        input  o_v_data, o_v_valid,
        output i_v_ready
    );
endinterface

// File: rtl/qkv_read_scheduler.sv
// Tile-by-tile read scheduler: streams Q/K line pairs then V lines for each tile
// of the spike RAMs, through 2-entry FIFOs with credit-limited read issue.
module qkv_read_scheduler #(
    parameter int LINES = 768,
    parameter int TILE  = 32,
    parameter int DW    = 128
) (
    input  logic                 s_clk,
    input  logic                 s_rst_n,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic                 i_SpikesTmpRam_Ready,
    qkv_read_scheduler_if.master bus,
    output logic [9:0]           o_tile_idx,
    output logic                 o_busy,
    output logic                 o_done
);
    localparam int            CW        = $clog2(TILE + 1);
    localparam logic [CW-1:0] TILE_C    = CW'(TILE);
    localparam logic [CW-1:0] LAST_BEAT = CW'(TILE - 1);
    localparam logic [9:0]    LAST_TILE = 10'(LINES / TILE - 1);

    typedef enum logic [2:0] {IDLE, WAIT_RDY, QK, V, DONE} state_t;

    state_t          r_state;
    logic [9:0]      r_tile;
    logic [CW-1:0]   r_rd_cnt;
    logic [CW-1:0]   r_acc_cnt;
    logic            r_busy;
    logic            r_done;
    logic [9:0]      r_qk_addr;
    logic [9:0]      r_v_addr;

    logic [2*DW-1:0] r_qk_mem [2];
    logic            r_qk_wp;
    logic            r_qk_rp;
    logic [1:0]      r_qk_cnt;
    logic            r_qk_ret;
    logic [DW-1:0]   r_v_mem [2];
    logic            r_v_wp;
    logic            r_v_rp;
    logic [1:0]      r_v_cnt;
    logic            r_v_ret;

    logic [9:0]      w_line;
    logic            w_qk_pop;
    logic            w_v_pop;
    logic [2:0]      w_qk_load;
    logic [2:0]      w_v_load;
    logic            w_qk_issue;
    logic            w_v_issue;

    // Issue is decided in the cycle the address is driven, counting this cycle's
    // pop as freed space: keeps one beat per cycle with only two entries of storage.
    always_comb begin
        w_line     = 10'(r_tile * TILE) + 10'(r_rd_cnt);
        w_qk_pop   = (r_qk_cnt != 2'd0) && bus.i_qk_ready;
        w_v_pop    = (r_v_cnt != 2'd0) && bus.i_v_ready;
        w_qk_load  = {1'b0, r_qk_cnt} + {2'b0, r_qk_ret} - {2'b0, w_qk_pop};
        w_v_load   = {1'b0, r_v_cnt} + {2'b0, r_v_ret} - {2'b0, w_v_pop};
        w_qk_issue = (r_state == QK) && (r_rd_cnt != TILE_C) && !i_abort && (w_qk_load < 3'd2);
        w_v_issue  = (r_state == V) && (r_rd_cnt != TILE_C) && !i_abort && (w_v_load < 3'd2);
    end

    assign bus.o_QueryRam_rdaddr = w_qk_issue ? w_line : r_qk_addr;
    assign bus.o_KeyRam_rdaddr   = w_qk_issue ? w_line : r_qk_addr;
    assign bus.o_ValueRam_rdaddr = w_v_issue ? w_line : r_v_addr;
    assign bus.o_q_data          = r_qk_mem[r_qk_rp][2*DW-1:DW];
    assign bus.o_k_data          = r_qk_mem[r_qk_rp][DW-1:0];
    assign bus.o_qk_valid        = (r_qk_cnt != 2'd0);
    assign bus.o_v_data          = r_v_mem[r_v_rp];
    assign bus.o_v_valid         = (r_v_cnt != 2'd0);
    assign o_tile_idx            = r_tile;
    assign o_busy                = r_busy;
    assign o_done                = r_done;

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_qk_mem[0] <= '0;
            r_qk_mem[1] <= '0;
            r_qk_wp     <= 1'b0;
            r_qk_rp     <= 1'b0;
            r_qk_cnt    <= '0;
            r_qk_ret    <= 1'b0;
        end else if (i_abort) begin
            r_qk_wp  <= 1'b0;
            r_qk_rp  <= 1'b0;
            r_qk_cnt <= '0;
            r_qk_ret <= 1'b0;
        end else begin
            r_qk_ret <= w_qk_issue;
            if (r_qk_ret) begin
                r_qk_mem[r_qk_wp] <= {bus.i_QueryRam_out, bus.i_KeyRam_out};
                r_qk_wp           <= ~r_qk_wp;
            end
            if (w_qk_pop) begin
                r_qk_rp <= ~r_qk_rp;
            end
            r_qk_cnt <= r_qk_cnt + 2'(r_qk_ret) - 2'(w_qk_pop);
        end
    end

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_v_mem[0] <= '0;
            r_v_mem[1] <= '0;
            r_v_wp     <= 1'b0;
            r_v_rp     <= 1'b0;
            r_v_cnt    <= '0;
            r_v_ret    <= 1'b0;
        end else if (i_abort) begin
            r_v_wp  <= 1'b0;
            r_v_rp  <= 1'b0;
            r_v_cnt <= '0;
            r_v_ret <= 1'b0;
        end else begin
            r_v_ret <= w_v_issue;
            if (r_v_ret) begin
                r_v_mem[r_v_wp] <= bus.i_ValueRam_out;
                r_v_wp          <= ~r_v_wp;
            end
            if (w_v_pop) begin
                r_v_rp <= ~r_v_rp;
            end
            r_v_cnt <= r_v_cnt + 2'(r_v_ret) - 2'(w_v_pop);
        end
    end

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_state   <= IDLE;
            r_tile    <= '0;
            r_rd_cnt  <= '0;
            r_acc_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_qk_addr <= '0;
            r_v_addr  <= '0;
        end else if (i_abort) begin
            r_state   <= IDLE;
            r_tile    <= '0;
            r_rd_cnt  <= '0;
            r_acc_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_qk_issue) begin
                r_qk_addr <= w_line;
                r_rd_cnt  <= r_rd_cnt + 1'b1;
            end
            if (w_v_issue) begin
                r_v_addr <= w_line;
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_rd_cnt  <= '0;
                        r_acc_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= i_SpikesTmpRam_Ready ? QK : WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (i_SpikesTmpRam_Ready) begin
                        r_state <= QK;
                    end
                end
                QK: begin
                    if (w_qk_pop) begin
                        if (r_acc_cnt == LAST_BEAT) begin
                            r_rd_cnt  <= '0;
                            r_acc_cnt <= '0;
                            r_state   <= V;
                        end else begin
                            r_acc_cnt <= r_acc_cnt + 1'b1;
                        end
                    end
                end
                V: begin
                    if (w_v_pop) begin
                        if (r_acc_cnt == LAST_BEAT) begin
                            r_rd_cnt  <= '0;
                            r_acc_cnt <= '0;
                            if (r_tile == LAST_TILE) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= DONE;
                            end else begin
                                r_tile  <= r_tile + 10'd1;
                                r_state <= QK;
                            end
                        end else begin
                            r_acc_cnt <= r_acc_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_tile  <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qkv_read_scheduler.sv
// Directed and randomized bench for qkv_read_scheduler (LINES=8, TILE=4) with a
// queue-based model of the expected beat order and RAM contents.
module tb_qkv_read_scheduler;
    localparam int LINES = 8;
    localparam int TILE  = 4;
    localparam int DW    = 16;
    localparam int NT    = LINES / TILE;
    localparam int AW    = 3;

    typedef struct {
        bit is_v;
        int addr;
    } beat_t;

    logic       s_clk   = 1'b0;
    logic       s_rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_abort = 1'b0;
    logic       i_rdy   = 1'b0;
    logic [9:0] tile_idx;
    logic       busy;
    logic       done;

    qkv_read_scheduler_if #(.DW(DW)) bus ();

    qkv_read_scheduler #(.LINES(LINES), .TILE(TILE), .DW(DW)) dut (
        .s_clk                (s_clk),
        .s_rst_n              (s_rst_n),
        .i_start              (i_start),
        .i_abort              (i_abort),
        .i_SpikesTmpRam_Ready (i_rdy),
        .bus                  (bus),
        .o_tile_idx           (tile_idx),
        .o_busy               (busy),
        .o_done               (done)
    );

    always #5 s_clk = ~s_clk;

    logic [DW-1:0] qmem [LINES];
    logic [DW-1:0] kmem [LINES];
    logic [DW-1:0] vmem [LINES];

    always @(posedge s_clk) begin
        bus.i_QueryRam_out <= qmem[bus.o_QueryRam_rdaddr[AW-1:0]];
        bus.i_KeyRam_out   <= kmem[bus.o_KeyRam_rdaddr[AW-1:0]];
        bus.i_ValueRam_out <= vmem[bus.o_ValueRam_rdaddr[AW-1:0]];
    end

    beat_t exp_q[$];
    int    checks   = 0;
    int    errors   = 0;
    int    done_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Whole-pass expectation: for each tile, TILE Q/K lines then TILE V lines.
    task automatic new_pass();
        exp_q.delete();
        for (int i = 0; i < LINES; i++) begin
            qmem[i] = DW'($urandom);
            kmem[i] = DW'($urandom);
            vmem[i] = DW'($urandom);
        end
        for (int t = 0; t < NT; t++) begin
            for (int i = 0; i < TILE; i++) exp_q.push_back('{is_v: 1'b0, addr: t * TILE + i});
            for (int i = 0; i < TILE; i++) exp_q.push_back('{is_v: 1'b1, addr: t * TILE + i});
        end
    endtask

    task automatic next_cycle();
        @(posedge s_clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen;
        int d0;
        seen = 1'b0;
        d0   = done_cnt;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge s_clk);
            seen = done;
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'(1));
        repeat (3) @(negedge s_clk);
        chk({tag, "_done_once"}, 64'(done_cnt - d0), 64'(1));
        chk({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
    endtask

    logic          hold_qk = 1'b0;
    logic          hold_v  = 1'b0;
    logic [DW-1:0] pq, pk, pv;
    beat_t         mon_e;

    always @(negedge s_clk) begin
        if (s_rst_n) begin
            chk("valid_excl", 64'(bus.o_qk_valid & bus.o_v_valid), 64'(0));
            chk("addr_max", 64'((bus.o_QueryRam_rdaddr < LINES) && (bus.o_KeyRam_rdaddr < LINES)
                                && (bus.o_ValueRam_rdaddr < LINES)), 64'(1));
            if (hold_qk && bus.o_qk_valid) begin
                chk("q_stable", 64'(bus.o_q_data), 64'(pq));
                chk("k_stable", 64'(bus.o_k_data), 64'(pk));
            end
            if (hold_v && bus.o_v_valid) chk("v_stable", 64'(bus.o_v_data), 64'(pv));
            if (bus.o_qk_valid && bus.i_qk_ready) begin
                chk("qk_expected", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("qk_kind", 64'(mon_e.is_v), 64'(0));
                    chk("q_data", 64'(bus.o_q_data), 64'(qmem[mon_e.addr]));
                    chk("k_data", 64'(bus.o_k_data), 64'(kmem[mon_e.addr]));
                end
            end
            if (bus.o_v_valid && bus.i_v_ready) begin
                chk("v_expected", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("v_kind", 64'(mon_e.is_v), 64'(1));
                    chk("v_data", 64'(bus.o_v_data), 64'(vmem[mon_e.addr]));
                end
            end
            hold_qk = bus.o_qk_valid & ~bus.i_qk_ready;
            hold_v  = bus.o_v_valid & ~bus.i_v_ready;
            pq = bus.o_q_data;
            pk = bus.o_k_data;
            pv = bus.o_v_data;
            if (done) done_cnt++;
        end else begin
            hold_qk = 1'b0;
            hold_v  = 1'b0;
        end
    end

    initial begin
        int d0;
        int delay;
        bit seen;

        bus.i_qk_ready = 1'b0;
        bus.i_v_ready  = 1'b0;
        for (int i = 0; i < LINES; i++) begin
            qmem[i] = '0;
            kmem[i] = '0;
            vmem[i] = '0;
        end

        // Reset values
        repeat (3) @(posedge s_clk);
        @(negedge s_clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_tile", 64'(tile_idx), 64'(0));
        chk("rst_qaddr", 64'(bus.o_QueryRam_rdaddr), 64'(0));
        chk("rst_kaddr", 64'(bus.o_KeyRam_rdaddr), 64'(0));
        chk("rst_vaddr", 64'(bus.o_ValueRam_rdaddr), 64'(0));
        chk("rst_qk_valid", 64'(bus.o_qk_valid), 64'(0));
        chk("rst_v_valid", 64'(bus.o_v_valid), 64'(0));
        chk("rst_data", 64'({bus.o_q_data, bus.o_k_data, bus.o_v_data}), 64'(0));
        next_cycle();
        s_rst_n = 1'b1;

        // Full pass, readies held high, stray starts while busy
        new_pass();
        bus.i_qk_ready = 1'b1;
        bus.i_v_ready  = 1'b1;
        i_rdy          = 1'b1;
        next_cycle();
        i_start = 1'b1;
        @(negedge s_clk);
        chk("s1_c0_busy", 64'(busy), 64'(0));
        for (int c = 1; c <= 27; c++) begin
            next_cycle();
            i_start = (c == 5 || c == 15);
            @(negedge s_clk);
            if (c <= 4) begin
                chk("s1_qaddr_t0", 64'(bus.o_QueryRam_rdaddr), 64'(c - 1));
                chk("s1_kaddr_t0", 64'(bus.o_KeyRam_rdaddr), 64'(c - 1));
            end
            if (c >= 2 && c <= 6) chk("s1_qk_valid", 64'(bus.o_qk_valid), 64'(c >= 3));
            if (c >= 7 && c <= 10) chk("s1_vaddr_t0", 64'(bus.o_ValueRam_rdaddr), 64'(c - 7));
            if (c == 8 || c == 9) chk("s1_v_valid", 64'(bus.o_v_valid), 64'(c == 9));
            if (c >= 13 && c <= 16) chk("s1_qaddr_t1", 64'(bus.o_QueryRam_rdaddr), 64'(c - 9));
            if (c >= 19 && c <= 22) chk("s1_vaddr_t1", 64'(bus.o_ValueRam_rdaddr), 64'(c - 15));
            chk("s1_done", 64'(done), 64'(c == 25));
            if (c == 8) chk("s1_busy", 64'(busy), 64'(1));
            if (c == 14) chk("s1_tile1", 64'(tile_idx), 64'(1));
            if (c == 25) chk("s1_busy_done", 64'(busy), 64'(0));
            if (c == 26) chk("s1_tile_clr", 64'(tile_idx), 64'(0));
        end
        i_start = 1'b0;
        chk("s1_drained", 64'(exp_q.size()), 64'(0));

        // Start while RAMs not ready
        new_pass();
        i_rdy = 1'b0;
        next_cycle();
        i_start = 1'b1;
        @(negedge s_clk);
        for (int c = 1; c <= 12; c++) begin
            next_cycle();
            i_start = 1'b0;
            i_rdy   = (c >= 10);
            @(negedge s_clk);
            if (c <= 10) begin
                chk("s2_busy", 64'(busy), 64'(1));
                chk("s2_qaddr_hold", 64'(bus.o_QueryRam_rdaddr), 64'(7));
                chk("s2_qk_valid", 64'(bus.o_qk_valid), 64'(0));
            end
            if (c == 11) chk("s2_first_addr", 64'(bus.o_QueryRam_rdaddr), 64'(0));
            if (c == 12) chk("s2_second_addr", 64'(bus.o_QueryRam_rdaddr), 64'(1));
        end
        wait_done("s2", 200);

        // Q/K back-pressure in cycles 3..9
        new_pass();
        next_cycle();
        i_start = 1'b1;
        @(negedge s_clk);
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            i_start        = 1'b0;
            bus.i_qk_ready = !(c >= 3 && c <= 9);
            @(negedge s_clk);
            if (c >= 3 && c <= 9) begin
                chk("s3_qaddr_stall", 64'(bus.o_QueryRam_rdaddr), 64'(1));
                chk("s3_qk_valid", 64'(bus.o_qk_valid), 64'(1));
                chk("s3_q_head", 64'(bus.o_q_data), 64'(qmem[0]));
                chk("s3_k_head", 64'(bus.o_k_data), 64'(kmem[0]));
            end
            if (c == 10) chk("s3_qaddr_resume", 64'(bus.o_QueryRam_rdaddr), 64'(2));
        end
        wait_done("s3", 200);

        // Abort in tile 1 V phase, then abort+start together, then replay
        new_pass();
        next_cycle();
        i_start = 1'b1;
        @(negedge s_clk);
        for (int c = 1; c <= 21; c++) begin
            next_cycle();
            i_start = 1'b0;
            i_abort = (c == 20);
            @(negedge s_clk);
            if (c == 20) begin
                chk("s4_pre_busy", 64'(busy), 64'(1));
                chk("s4_pre_tile", 64'(tile_idx), 64'(1));
            end
        end
        chk("s4_busy", 64'(busy), 64'(0));
        chk("s4_qk_valid", 64'(bus.o_qk_valid), 64'(0));
        chk("s4_v_valid", 64'(bus.o_v_valid), 64'(0));
        chk("s4_tile", 64'(tile_idx), 64'(0));
        i_abort = 1'b0;
        d0 = done_cnt;
        for (int c = 22; c <= 30; c++) begin
            next_cycle();
            @(negedge s_clk);
            chk("s4_no_done", 64'(done), 64'(0));
            chk("s4_v_flushed", 64'(bus.o_v_valid), 64'(0));
        end
        chk("s4_done_cnt", 64'(done_cnt - d0), 64'(0));
        exp_q.delete();
        next_cycle();
        i_start = 1'b1;
        i_abort = 1'b1;
        @(negedge s_clk);
        next_cycle();
        i_start = 1'b0;
        i_abort = 1'b0;
        @(negedge s_clk);
        chk("s4_abort_prio_busy", 64'(busy), 64'(0));
        chk("s4_abort_prio_addr", 64'(bus.o_QueryRam_rdaddr), 64'(7));
        new_pass();
        next_cycle();
        i_start = 1'b1;
        @(negedge s_clk);
        next_cycle();
        i_start = 1'b0;
        @(negedge s_clk);
        chk("s4_replay_addr", 64'(bus.o_QueryRam_rdaddr), 64'(0));
        chk("s4_replay_tile", 64'(tile_idx), 64'(0));
        wait_done("s4_replay", 200);

        // Reset pulse mid-QK
        new_pass();
        next_cycle();
        i_start = 1'b1;
        @(negedge s_clk);
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            i_start = 1'b0;
            @(negedge s_clk);
        end
        chk("s5_pre_valid", 64'(bus.o_qk_valid), 64'(1));
        #2;
        s_rst_n = 1'b0;
        #1;
        chk("s5_busy", 64'(busy), 64'(0));
        chk("s5_qk_valid", 64'(bus.o_qk_valid), 64'(0));
        chk("s5_qaddr", 64'(bus.o_QueryRam_rdaddr), 64'(0));
        chk("s5_kaddr", 64'(bus.o_KeyRam_rdaddr), 64'(0));
        chk("s5_data", 64'({bus.o_q_data, bus.o_k_data}), 64'(0));
        chk("s5_tile", 64'(tile_idx), 64'(0));
        exp_q.delete();
        d0 = done_cnt;
        repeat (2) @(posedge s_clk);
        next_cycle();
        s_rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            next_cycle();
            @(negedge s_clk);
            chk("s5_idle_busy", 64'(busy), 64'(0));
            chk("s5_idle_valid", 64'(bus.o_qk_valid), 64'(0));
        end
        chk("s5_no_done", 64'(done_cnt - d0), 64'(0));

        // Randomized readies, RAM-ready delay and stray starts
        for (int p = 0; p < 4; p++) begin
            new_pass();
            delay = int'($urandom_range(0, 3));
            i_rdy = (delay == 0);
            next_cycle();
            i_start = 1'b1;
            @(negedge s_clk);
            seen = 1'b0;
            d0   = done_cnt;
            for (int n = 1; n <= 400 && !seen; n++) begin
                next_cycle();
                i_start        = ($urandom_range(0, 9) == 0);
                i_rdy          = (n >= delay);
                bus.i_qk_ready = ($urandom_range(0, 3) != 0);
                bus.i_v_ready  = ($urandom_range(0, 3) != 0);
                @(negedge s_clk);
                seen = done;
            end
            i_start        = 1'b0;
            bus.i_qk_ready = 1'b1;
            bus.i_v_ready  = 1'b1;
            chk("rnd_done_seen", 64'(seen), 64'(1));
            repeat (3) @(negedge s_clk);
            chk("rnd_done_once", 64'(done_cnt - d0), 64'(1));
            chk("rnd_drained", 64'(exp_q.size()), 64'(0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
